// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage with valid/ready handshake, stall hold, flush and an
// optional two-entry skid buffer (main entry M drives EX, skid entry S
// catches the one in-flight instruction when in_ready is registered).
module id_ex_stage #(
    parameter int CTRL_W    = 12,
    parameter int PAYLOAD_W = 339,
    parameter int SKID      = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     bubble_count
);

    localparam bit HAS_SKID = (SKID != 0);

    logic                 r_m_valid;
    logic                 r_s_valid;
    logic                 r_in_ready;
    logic [CTRL_W-1:0]    r_m_ctrl;
    logic [CTRL_W-1:0]    r_s_ctrl;
    logic [PAYLOAD_W-1:0] r_m_payload;
    logic [PAYLOAD_W-1:0] r_s_payload;
    logic [CNT_W-1:0]     r_bubble;

    logic w_in_ready;
    logic w_accept;
    logic w_transfer;
    logic w_m_valid_n;
    logic w_s_valid_n;
    logic w_load_m_in;
    logic w_load_m_s;
    logic w_load_s_in;
    logic w_bubble_inc;

    // With the skid buffer in_ready is a flop so the upstream path never sees out_ready.
    assign w_in_ready   = HAS_SKID ? r_in_ready : (out_ready || !r_m_valid);
    assign w_accept     = in_valid && w_in_ready && !flush;
    assign w_transfer   = r_m_valid && out_ready;
    assign w_bubble_inc = out_ready && !r_m_valid && (r_bubble != {CNT_W{1'b1}});

    // Next occupancy: flush empties everything; otherwise FIFO fill/drain of M and S.
    always_comb begin
        w_m_valid_n = r_m_valid;
        w_s_valid_n = r_s_valid;
        w_load_m_in = 1'b0;
        w_load_m_s  = 1'b0;
        w_load_s_in = 1'b0;
        if (flush) begin
            w_m_valid_n = 1'b0;
            w_s_valid_n = 1'b0;
        end else if (!r_m_valid) begin
            if (w_accept) begin
                w_m_valid_n = 1'b1;
                w_load_m_in = 1'b1;
            end
        end else if (!r_s_valid) begin
            if (w_accept && w_transfer) begin
                w_load_m_in = 1'b1;
            end else if (w_accept && HAS_SKID) begin
                w_s_valid_n = 1'b1;
                w_load_s_in = 1'b1;
            end else if (w_transfer) begin
                w_m_valid_n = 1'b0;
            end
        end else if (w_transfer) begin
            w_load_m_s  = 1'b1;
            w_s_valid_n = 1'b0;
        end
    end

    // Control state: valid bits, registered ready and the saturating bubble counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
            r_bubble   <= '0;
        end else begin
            r_m_valid  <= w_m_valid_n;
            r_s_valid  <= w_s_valid_n;
            r_in_ready <= !w_s_valid_n;
            if (w_bubble_inc) begin
                r_bubble <= r_bubble + CNT_W'(1);
            end
        end
    end

    // Main entry data: cleared on reset so EX sees zeros; held bit-exact during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_ctrl    <= '0;
            r_m_payload <= '0;
        end else if (w_load_m_in) begin
            r_m_ctrl    <= in_ctrl;
            r_m_payload <= in_payload;
        end else if (w_load_m_s) begin
            r_m_ctrl    <= r_s_ctrl;
            r_m_payload <= r_s_payload;
        end
    end

    // Skid entry data: only meaningful while r_s_valid is set, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_load_s_in) begin
            r_s_ctrl    <= in_ctrl;
            r_s_payload <= in_payload;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_m_valid;
    assign out_ctrl     = r_m_valid ? r_m_ctrl : '0;
    assign out_payload  = r_m_payload;
    assign occupancy    = {1'b0, r_m_valid} + {1'b0, r_s_valid};
    assign bubble_count = r_bubble;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: instance A uses the skid buffer with a 16-bit
// counter, instance B runs without skid and with a 4-bit counter so that
// saturation is reached quickly. Both are checked against a queue model.
module tb_id_ex_stage;

    localparam int PW = 339;
    localparam int CW = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          a_iv, a_ir, a_fl, a_ov, a_or;
    logic [CW-1:0] a_ctrl, a_oc;
    logic [PW-1:0] a_pl, a_op;
    logic [1:0]    a_occ;
    logic [15:0]   a_bc;

    logic          b_iv, b_ir, b_fl, b_ov, b_or;
    logic [CW-1:0] b_ctrl, b_oc;
    logic [PW-1:0] b_pl, b_op;
    logic [1:0]    b_occ;
    logic [3:0]    b_bc;

    id_ex_stage #(.CTRL_W(CW), .PAYLOAD_W(PW), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir),
        .in_ctrl(a_ctrl), .in_payload(a_pl), .flush(a_fl),
        .out_valid(a_ov), .out_ready(a_or), .out_ctrl(a_oc),
        .out_payload(a_op), .occupancy(a_occ), .bubble_count(a_bc));

    id_ex_stage #(.CTRL_W(CW), .PAYLOAD_W(PW), .SKID(0), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir),
        .in_ctrl(b_ctrl), .in_payload(b_pl), .flush(b_fl),
        .out_valid(b_ov), .out_ready(b_or), .out_ctrl(b_oc),
        .out_payload(b_op), .occupancy(b_occ), .bubble_count(b_bc));

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [PW-1:0] pl;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int   ba, bb;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct {
        bit            iv;
        logic [63:0]   pc;
        bit            ordy;
        bit            fl;
        bit            ev;
        logic [CW-1:0] ectrl;
        logic [63:0]   epc;
        int            eocc;
        bit            erdy;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] rnd_pl();
        logic [351:0] t;
        for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom();
        return t[PW-1:0];
    endfunction

    // Compare both DUTs with the queue model, advance the model, then clock.
    task automatic cycle();
        bit acc;
        chk("a_out_valid", PW'(a_ov), PW'(qa.size() > 0));
        chk("a_out_ctrl", PW'(a_oc), (qa.size() > 0) ? PW'(qa[0].ctrl) : '0);
        if (qa.size() > 0) chk("a_out_payload", a_op, qa[0].pl);
        chk("a_occupancy", PW'(a_occ), PW'(qa.size()));
        chk("a_in_ready", PW'(a_ir), PW'(qa.size() < 2));
        chk("a_bubble", PW'(a_bc), PW'(ba));
        chk("b_out_valid", PW'(b_ov), PW'(qb.size() > 0));
        chk("b_out_ctrl", PW'(b_oc), (qb.size() > 0) ? PW'(qb[0].ctrl) : '0);
        if (qb.size() > 0) chk("b_out_payload", b_op, qb[0].pl);
        chk("b_occupancy", PW'(b_occ), PW'(qb.size()));
        chk("b_in_ready", PW'(b_ir), PW'(qb.size() == 0 || b_or));
        chk("b_bubble", PW'(b_bc), PW'(bb));
        if (reset) begin
            qa.delete(); qb.delete(); ba = 0; bb = 0;
        end else begin
            if (a_or && qa.size() == 0 && ba < 65535) ba++;
            if (a_fl) qa.delete();
            else begin
                acc = a_iv && (qa.size() < 2);
                if (qa.size() > 0 && a_or) void'(qa.pop_front());
                if (acc) qa.push_back('{a_ctrl, a_pl});
            end
            if (b_or && qb.size() == 0 && bb < 15) bb++;
            if (b_fl) qb.delete();
            else begin
                acc = b_iv && (qb.size() == 0 || b_or);
                if (qb.size() > 0 && b_or) void'(qb.pop_front());
                if (acc) qb.push_back('{b_ctrl, b_pl});
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [PW-1:0] hold_pl;

    initial begin
        tbl[0]  = '{1, 64'h00, 1, 0, 0, 12'h000, 64'h00, 0, 1};
        tbl[1]  = '{1, 64'h04, 1, 0, 1, 12'h0A5, 64'h00, 1, 1};
        tbl[2]  = '{1, 64'h08, 1, 0, 1, 12'h0A5, 64'h04, 1, 1};
        tbl[3]  = '{0, 64'h00, 1, 0, 1, 12'h0A5, 64'h08, 1, 1};
        tbl[4]  = '{0, 64'h00, 1, 0, 0, 12'h000, 64'h00, 0, 1};
        tbl[5]  = '{1, 64'h10, 1, 0, 0, 12'h000, 64'h00, 0, 1};
        tbl[6]  = '{1, 64'h14, 0, 0, 1, 12'h0A5, 64'h10, 1, 1};
        tbl[7]  = '{1, 64'h18, 0, 0, 1, 12'h0A5, 64'h10, 2, 0};
        tbl[8]  = '{1, 64'h18, 1, 0, 1, 12'h0A5, 64'h10, 2, 0};
        tbl[9]  = '{1, 64'h18, 1, 0, 1, 12'h0A5, 64'h14, 1, 1};
        tbl[10] = '{0, 64'h00, 1, 0, 1, 12'h0A5, 64'h18, 1, 1};
        tbl[11] = '{0, 64'h00, 1, 0, 0, 12'h000, 64'h00, 0, 1};
        tbl[12] = '{1, 64'h30, 0, 0, 0, 12'h000, 64'h00, 0, 1};
        tbl[13] = '{1, 64'h34, 0, 0, 1, 12'h0A5, 64'h30, 1, 1};
        tbl[14] = '{1, 64'h20, 0, 1, 1, 12'h0A5, 64'h30, 2, 0};
        tbl[15] = '{0, 64'h00, 1, 0, 0, 12'h000, 64'h00, 0, 1};
        tbl[16] = '{0, 64'h00, 1, 0, 0, 12'h000, 64'h00, 0, 1};

        reset = 1'b1;
        a_iv = 1'b1; a_fl = 1'b0; a_or = 1'b1; a_ctrl = 12'h0A5; a_pl = '1;
        b_iv = 1'b1; b_fl = 1'b0; b_or = 1'b0; b_ctrl = 12'h0A5; b_pl = '1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        a_iv = 1'b0; b_iv = 1'b0;
        #1;
        chk("reset_a_payload", a_op, '0);
        chk("reset_b_payload", b_op, '0);
        chk("reset_a_bubble", PW'(a_bc), '0);

        // Directed table on the skid instance: streaming, stall with fill, flush at occupancy 2.
        for (int i = 0; i < 17; i++) begin
            a_iv = tbl[i].iv; a_pl = PW'(tbl[i].pc); a_ctrl = 12'h0A5;
            a_or = tbl[i].ordy; a_fl = tbl[i].fl;
            #1;
            chk($sformatf("tbl%0d_valid", i), PW'(a_ov), PW'(tbl[i].ev));
            chk($sformatf("tbl%0d_ctrl", i), PW'(a_oc), PW'(tbl[i].ectrl));
            if (tbl[i].ev) chk($sformatf("tbl%0d_pc", i), a_op, PW'(tbl[i].epc));
            chk($sformatf("tbl%0d_occ", i), PW'(a_occ), PW'(tbl[i].eocc));
            chk($sformatf("tbl%0d_ready", i), PW'(a_ir), PW'(tbl[i].erdy));
            cycle();
        end

        // Five-cycle stall holds M exactly and counts no bubbles.
        hold_pl = rnd_pl();
        a_iv = 1'b1; a_pl = hold_pl; a_ctrl = 12'h0A5; a_or = 1'b0; a_fl = 1'b0;
        #1; cycle();
        a_iv = 1'b0; a_pl = rnd_pl();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_ctrl", PW'(a_oc), PW'(12'h0A5));
            chk("stall_payload", a_op, hold_pl);
            cycle();
        end
        a_or = 1'b1;
        #1; cycle();
        #1; cycle();

        // No-skid instance: ready drops with a stalled valid entry, returns combinationally.
        b_iv = 1'b1; b_pl = PW'(64'h40); b_ctrl = 12'h011; b_or = 1'b0;
        #1; cycle();
        b_pl = PW'(64'h44); b_ctrl = 12'h022;
        #1;
        chk("b_stall_ready", PW'(b_ir), PW'(1'b0));
        cycle();
        b_or = 1'b1;
        #1;
        chk("b_release_ready", PW'(b_ir), PW'(1'b1));
        chk("b_release_pc", b_op, PW'(64'h40));
        cycle();
        b_iv = 1'b0;
        #1;
        chk("b_reload_pc", b_op, PW'(64'h44));
        chk("b_reload_ctrl", PW'(b_oc), PW'(12'h022));
        cycle();

        // Bubble counter saturation on the 4-bit counter, then reset clears it.
        for (int k = 0; k < 20; k++) begin
            #1; cycle();
        end
        #1;
        chk("b_bubble_sat", PW'(b_bc), PW'(4'hF));

        // Reset together with flush and a valid input: reset wins, stage is empty.
        a_iv = 1'b1; a_fl = 1'b1; a_pl = PW'(64'h50); a_or = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0; a_iv = 1'b0; a_fl = 1'b0;
        #1;
        chk("rst_b_bubble", PW'(b_bc), '0);
        chk("rst_a_occ", PW'(a_occ), '0);
        chk("rst_a_ready", PW'(a_ir), PW'(1'b1));
        cycle();

        // Random traffic on both instances against the queue model.
        for (int k = 0; k < 800; k++) begin
            a_iv = ($urandom_range(0, 3) != 0); a_or = ($urandom_range(0, 2) != 0);
            a_fl = ($urandom_range(0, 15) == 0); a_ctrl = CW'($urandom()); a_pl = rnd_pl();
            b_iv = ($urandom_range(0, 3) != 0); b_or = ($urandom_range(0, 2) != 0);
            b_fl = ($urandom_range(0, 15) == 0); b_ctrl = CW'($urandom()); b_pl = rnd_pl();
            reset = ($urandom_range(0, 63) == 0);
            #1; cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
